// File: rtl/dct_pkg.sv
// Shared widths, FSM state type and sign-extension helper
// for the DCT input butterfly stage.
package dct_pkg;

  localparam int PIX_W   = 8;
  localparam int STORE_W = 9;
  localparam int X_W     = 12;
  localparam int ROW_LEN = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVEN,
    S_ODD
  } state_e;

  function automatic logic [X_W-1:0] sext(
    input logic [STORE_W-1:0] v
  );
    return {{(X_W-STORE_W){v[STORE_W-1]}}, v};
  endfunction

endpackage

// File: rtl/dct_row_buf.sv
// Ping-pong row buffer: two 8-entry banks with write pointer,
// write/read bank selects and per-bank full flags.
module dct_row_buf
  import dct_pkg::*;
(
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       wr_en,
  input  logic [STORE_W-1:0]         wr_data,
  input  logic                       rel,
  output logic                       pix_ready,
  output logic                       rd_full,
  output logic                       alt_full,
  output logic [ROW_LEN*STORE_W-1:0] rd_row
);

  logic [STORE_W-1:0] mem [0:1][0:ROW_LEN-1];
  logic [2:0]         wr_ptr;
  logic               wr_bank;
  logic               rd_bank;
  logic [1:0]         full_q;
  logic [1:0]         full_d;
  logic               wr_ok;
  logic               wr_last;

  // The bank being written is only full when both banks are.
  assign pix_ready = !full_q[wr_bank];
  assign wr_ok     = wr_en && pix_ready;
  assign wr_last   = wr_ok && (wr_ptr == 3'(ROW_LEN-1));
  assign rd_full   = full_q[rd_bank];
  assign alt_full  = full_q[!rd_bank];

  // Release and row completion always target different banks.
  always_comb begin
    full_d = full_q;
    if (rel)
      full_d[rd_bank] = 1'b0;
    if (wr_last)
      full_d[wr_bank] = 1'b1;
  end

  // Pointer, bank selects and full flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full_q  <= '0;
    end else begin
      full_q <= full_d;
      if (wr_ok)
        wr_ptr <= wr_ptr + 3'd1;
      if (wr_last)
        wr_bank <= !wr_bank;
      if (rel)
        rd_bank <= !rd_bank;
    end
  end

  // Pixel storage; contents are qualified by the full flags.
  always_ff @(posedge sys_clk) begin
    if (wr_ok)
      mem[wr_bank][wr_ptr] <= wr_data;
  end

  for (genvar g = 0; g < ROW_LEN; g++) begin : g_rd
    assign rd_row[g*STORE_W +: STORE_W] = mem[rd_bank][g];
  end

endmodule

// File: rtl/dct_bfly_in.sv
// DCT input butterfly: buffers rows, emits even/odd groups to DA.
// Optional LEVEL_SHIFT_EN stores pixels as pix_data-128.
module dct_bfly_in
  import dct_pkg::*;
#(
  parameter int HOLD_CYC = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic [X_W-1:0]   X0,
  output logic [X_W-1:0]   X1,
  output logic [X_W-1:0]   X2,
  output logic [X_W-1:0]   X3,
  output logic             DA_start,
  output logic             grp_odd
);

  logic [STORE_W-1:0]         st;
  logic [ROW_LEN*STORE_W-1:0] rd_row;
  logic                       rd_full;
  logic                       alt_full;
  logic                       rel;
  logic                       load;
  logic                       last;
  state_e                     state_q;
  state_e                     state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;
  logic [X_W-1:0]             sum [4];
  logic [X_W-1:0]             dif [4];

`ifdef LEVEL_SHIFT_EN
  assign st = {1'b0, pix_data} - STORE_W'(128);
`else
  assign st = {1'b0, pix_data};
`endif

  dct_row_buf u_buf (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (pix_valid),
    .wr_data   (st),
    .rel       (rel),
    .pix_ready (pix_ready),
    .rd_full   (rd_full),
    .alt_full  (alt_full),
    .rd_row    (rd_row)
  );

  for (genvar g = 0; g < 4; g++) begin : g_bf
    logic [X_W-1:0] a;
    logic [X_W-1:0] b;
    assign a      = sext(rd_row[g*STORE_W +: STORE_W]);
    assign b      = sext(rd_row[(7-g)*STORE_W +: STORE_W]);
    assign sum[g] = a + b;
    assign dif[g] = a - b;
  end

  assign last = (cnt_q == CNT_W'(HOLD_CYC-1));

  // State and hold-counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; load fires in the first cycle of each group.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rd_full)
          state_d = S_EVEN;
      end
      S_EVEN: begin
        load = (cnt_q == '0);
        if (last) begin
          cnt_d   = '0;
          state_d = S_ODD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ODD: begin
        load = (cnt_q == '0);
        if (last) begin
          rel     = 1'b1;
          cnt_d   = '0;
          state_d = alt_full ? S_EVEN : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered group outputs, updated only with the pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      DA_start <= 1'b0;
      grp_odd  <= 1'b0;
      X0       <= '0;
      X1       <= '0;
      X2       <= '0;
      X3       <= '0;
    end else begin
      DA_start <= load;
      if (load) begin
        grp_odd <= (state_q == S_ODD);
        X0 <= (state_q == S_ODD) ? dif[0] : sum[0];
        X1 <= (state_q == S_ODD) ? dif[1] : sum[1];
        X2 <= (state_q == S_ODD) ? dif[2] : sum[2];
        X3 <= (state_q == S_ODD) ? dif[3] : sum[3];
      end
    end
  end

endmodule

// File: tb/tb_dct_bfly_in.sv
// Scoreboard bench for dct_bfly_in: row-level reference model
// predicts group values, pulse cycles and pix_ready.
module tb_dct_bfly_in;

  localparam int HOLD = 6;
`ifdef LEVEL_SHIFT_EN
  localparam int OFS = 128;
`else
  localparam int OFS = 0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'd0;
  logic        pix_ready;
  logic [11:0] X0, X1, X2, X3;
  logic        DA_start;
  logic        grp_odd;

  dct_bfly_in #(.HOLD_CYC(HOLD)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .X0        (X0),
    .X1        (X1),
    .X2        (X2),
    .X3        (X3),
    .DA_start  (DA_start),
    .grp_odd   (grp_odd)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          cyc;
    logic        odd;
    logic [47:0] x;
  } exp_t;

  exp_t        eq[$];
  int          row_q[$];
  int          cq[$];
  int          rq[$];
  int          n_comp = 0;
  int          n_rel = 0;
  int          last_odd = -100;
  logic [47:0] last_x = '0;
  logic        last_g = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h",
               nm, cyc, act, req);
    end
  endtask

  // Row-level model: butterflies from plain arithmetic; timing
  // from "first group 2 edges after completion, groups HOLD apart".
  task automatic model_row(input int a_edge);
    int          p[8];
    logic [47:0] ev;
    logic [47:0] od;
    int          e;
    for (int i = 0; i < 8; i++) p[i] = row_q[i] - OFS;
    for (int i = 0; i < 4; i++) begin
      ev[47-12*i -: 12] = 12'(p[i] + p[7-i]);
      od[47-12*i -: 12] = 12'(p[i] - p[7-i]);
    end
    e = (a_edge + 2 > last_odd + HOLD) ? a_edge + 2 : last_odd + HOLD;
    eq.push_back('{cyc: e, odd: 1'b0, x: ev});
    eq.push_back('{cyc: e + HOLD, odd: 1'b1, x: od});
    last_odd = e + HOLD;
    cq.push_back(a_edge);
    rq.push_back(e + HOLD + HOLD - 1);
    row_q.delete();
  endtask

  // Monitor: samples on the falling edge, away from DUT updates.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      chk("rst_ready", 64'(pix_ready), 64'd1);
      chk("rst_da", 64'(DA_start), 64'd0);
      chk("rst_grp", 64'(grp_odd), 64'd0);
      chk("rst_x", 64'({X0, X1, X2, X3}), 64'd0);
      eq.delete(); row_q.delete(); cq.delete(); rq.delete();
      n_comp = 0; n_rel = 0; last_odd = -100;
      last_x = '0; last_g = 1'b0;
    end else begin
      while (cq.size() > 0 && cq[0] <= cyc) begin
        n_comp++;
        void'(cq.pop_front());
      end
      while (rq.size() > 0 && rq[0] <= cyc) begin
        n_rel++;
        void'(rq.pop_front());
      end
      chk("pix_ready", 64'(pix_ready), 64'((n_comp - n_rel) < 2));
      if (DA_start) begin
        chk("da_pending", 64'(eq.size() != 0), 64'd1);
        if (eq.size() != 0) begin
          exp_t e;
          e = eq.pop_front();
          chk("da_cycle", 64'(cyc), 64'(e.cyc));
          chk("grp_odd", 64'(grp_odd), 64'(e.odd));
          chk("x_group", 64'({X0, X1, X2, X3}), 64'(e.x));
        end
        last_x = {X0, X1, X2, X3};
        last_g = grp_odd;
      end else begin
        chk("x_hold", 64'({grp_odd, X0, X1, X2, X3}),
            64'({last_g, last_x}));
        if (eq.size() != 0) begin
          chk("da_missing", 64'(eq[0].cyc <= cyc), 64'd0);
          if (eq[0].cyc <= cyc) void'(eq.pop_front());
        end
      end
      if (pix_valid && pix_ready) begin
        row_q.push_back(int'(pix_data));
        if (row_q.size() == 8) model_row(cyc + 1);
      end
    end
  end

  task automatic send(input int v);
    int k = 0;
    pix_valid = 1'b1;
    pix_data  = 8'(v);
    forever begin
      @(negedge sys_clk);
      if (pix_ready) break;
      k++;
      if (k > 200) begin
        chk("ready_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      pix_data = 8'($urandom);
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge sys_clk); #1;
    pix_valid = 1'b0;
    sys_rst_n = 1'b0;
    repeat (n) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  task automatic send_const(input int v);
    for (int i = 0; i < 8; i++) send(v);
  endtask

  task automatic drain();
    int k = 0;
    while (eq.size() != 0 && k < 3000) begin
      @(negedge sys_clk);
      k++;
    end
    chk("drain_empty", 64'(eq.size()), 64'd0);
    idle(4);
  endtask

  initial begin
    #1 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 8; i++) send(i);
    idle(20);
    send_const(128);
    idle(20);
    send(255);
    for (int i = 0; i < 7; i++) send(0);
    idle(1);
    drain();

    for (int i = 0; i < 5; i++) send(100);
    do_reset(2);
    idle(5);
    send_const(10);
    idle(1);
    drain();

    for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 255)));
    idle(9);
    do_reset(3);
    idle(20);

    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 255)));
    idle(1);
    drain();

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 8; i++) begin
        send(int'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 15)));
    end
    idle(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dct_bfly_in.md
DCT_BFLY_IN -- requirements
Module: dct_bfly_in

Interface
REQ-001 HOLD_CYC, 6, cycles each group is held stable on X0..X3 after its DA_start pulse (legal range 4..15).
REQ-002 sys_clk  input  1  sole clock, rising edge.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 pix_valid  input  1  pixel present on pix_data.
REQ-005 pix_data  input  8  unsigned pixel; 8 consecutive accepted pixels form one row x0..x7.
REQ-006 pix_ready  output  1  block can accept a pixel; transfer occurs when pix_valid and pix_ready are both high on a rising edge.
REQ-007 X0, X1, X2, X3  output  12 each  signed butterfly results for the DA engine.
REQ-008 DA_start  output  1  one-cycle pulse marking new X0..X3 values.
REQ-009 grp_odd  output  1  0 = even group (sums) on X0..X3, 1 = odd group (differences).

Function
REQ-010 Pixels shall be stored in a ping-pong row buffer of two 8-entry banks; the write pointer shall wrap 7->0 and toggle the write bank when a row completes.
REQ-011 pix_ready shall be low only when both banks hold unconsumed rows; it shall be high after reset.
REQ-012 The read FSM shall have states IDLE, EVEN and ODD; IDLE->EVEN when a full bank is available, EVEN->ODD after HOLD_CYC cycles, ODD->EVEN if the other bank is full at that point, otherwise ODD->IDLE.
REQ-013 EVEN group: X0=x0+x7, X1=x1+x6, X2=x2+x5, X3=x3+x4, each sign-extended to 12 bits.
REQ-014 ODD group: X0=x0-x7, X1=x1-x6, X2=x2-x5, X3=x3-x4, each sign-extended to 12 bits.
REQ-015 X0..X3 and grp_odd shall be registered and shall change only in the cycle DA_start is high; they shall otherwise hold.
REQ-016 DA_start shall be high exactly one cycle on entry to EVEN and on entry to ODD; its first assertion for a row shall come 2 rising edges after the edge that accepts that row's 8th pixel, provided the FSM is IDLE.
REQ-017 A bank shall be released on the last ODD hold cycle; if a pixel completes the other bank on that same edge, both events shall take effect and no pixel shall be lost or duplicated.
REQ-018 pix_valid while pix_ready is low shall be ignored and shall not advance the write pointer.
REQ-019 Arithmetic shall use 12-bit signed with no saturation; the ranges -256..255 cannot overflow.

Reset
REQ-020 Reset shall force pix_ready=1, X0..X3=0, DA_start=0, grp_odd=0, FSM=IDLE, write pointer=0, write bank=0, both banks empty.
REQ-021 Reset asserted mid-row or mid-hold shall discard all partial and buffered rows, and no DA_start shall follow reset release until a new full row is accepted.

Configuration
REQ-022 With LEVEL_SHIFT_EN defined, each pixel shall be stored as the 9-bit signed value pix_data-128.
REQ-023 Without LEVEL_SHIFT_EN, each pixel shall be stored as the 9-bit zero-extended value pix_data.

Structure
REQ-024 Package dct_pkg shall hold PIX_W=8, STORE_W=9, X_W=12 and the FSM state type.
REQ-025 The ping-pong storage, pointers and full flags shall form sub-module dct_row_buf; the FSM and butterfly adders stay in dct_bfly_in.

Verification
REQ-026 LEVEL_SHIFT_EN defined, row 0,1,...,7 -> EVEN X0..X3 = -249 each; ODD X0..X3 = -7, -5, -3, -1; grp_odd 0 then 1.
REQ-027 Row of all 128 with LEVEL_SHIFT_EN -> both groups all zero; DA_start 2 edges after the 8th accept, then again HOLD_CYC cycles later.
REQ-028 Three back-to-back rows, pix_valid held high -> pix_ready drops after row 2 and rises after row 1 releases; 6 DA_start pulses in order; no gaps in the X sequence.
REQ-029 Without LEVEL_SHIFT_EN, row 255,0,0,0,0,0,0,0 -> EVEN X0=255, X1..X3=0; ODD X0=255, X1..X3=0.
REQ-030 Reset asserted after 5 pixels, then a full row of 10s (LEVEL_SHIFT_EN) -> exactly one EVEN group (-236 each) and one ODD group (0 each), no stale data.
